// File: rtl/stepdir_sequencer.sv
// stepdir_sequencer: queued step/direction pulse generator for a stepper driver.
// Commands {steps, period, dir} are buffered in a small FIFO and played out as
// step pulses of fixed high time with a rising-edge spacing of max(period, 2*PULSE_W).
// A direction change inserts a DIR_SETUP hold before the first step.
module stepdir_sequencer #(
  parameter int DEPTH     = 4,
  parameter int PULSE_W   = 2,
  parameter int DIR_SETUP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     abort,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [15:0]              cmd_steps,
  input  logic [23:0]              cmd_period,
  input  logic                     cmd_dir,
  output logic                     step,
  output logic                     dir,
  output logic                     en,
  output logic [31:0]              position,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 16 + 24 + 1;

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [24:0] PW25    = 25'(PULSE_W);
  localparam logic [24:0] PW_LAST = 25'(PULSE_W - 1);
  localparam logic [24:0] TWO_PW  = 25'(2 * PULSE_W);
  localparam logic [24:0] DS_LAST = 25'(DIR_SETUP - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  // FIFO storage and bookkeeping
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          push, pop;

  // Motion state
  state_t        state_reg, state_next;
  logic [24:0]   cnt_reg, cnt_next;
  logic [24:0]   low_len_reg, low_len_next;
  logic [15:0]   remaining_reg, remaining_next;
  logic [31:0]   position_reg, position_next;
  logic          dir_reg, dir_next;
  logic          step_reg, step_next;

  // Head-of-queue fields
  logic [15:0]   head_steps;
  logic [23:0]   head_period;
  logic          head_dir;
  logic [24:0]   period_ext, eff;
  logic          low_done;

  assign {head_steps, head_period, head_dir} = mem[rd_ptr_reg];

  // The low phase is computed at 25 bits so a full 24-bit period never truncates.
  assign period_ext = {1'b0, head_period};
  assign eff        = (period_ext > TWO_PW) ? period_ext : TWO_PW;
  assign low_done   = (cnt_reg == (low_len_reg - 25'd1));

  assign cmd_ready = (level_reg < DEPTH_L) && !abort;
  assign push      = cmd_valid && cmd_ready;

  // FIFO pointers and occupancy; abort flushes, simultaneous push/pop nets out.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (abort) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // FIFO write port (storage needs no reset; occupancy guards reads).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {cmd_steps, cmd_period, cmd_dir};
  end

  // State register plus the datapath registers that move with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      low_len_reg   <= TWO_PW - PW25;
      remaining_reg <= '0;
      position_reg  <= '0;
      dir_reg       <= 1'b0;
      step_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      low_len_reg   <= low_len_next;
      remaining_reg <= remaining_next;
      position_reg  <= position_next;
      dir_reg       <= dir_next;
      step_reg      <= step_next;
    end
  end

  // Next-state decision: pop/launch in IDLE, timed phases, enable stall at end of LOW.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if ((level_reg != '0) && enable && (head_steps != 16'd0))
          state_next = (head_dir != dir_reg) ? SETUP : HIGH;
      end
      SETUP: begin
        if (cnt_reg == DS_LAST) state_next = HIGH;
      end
      HIGH: begin
        if (cnt_reg == PW_LAST) state_next = LOW;
      end
      LOW: begin
        if (low_done) begin
          if (remaining_reg <= 16'd1) state_next = IDLE;
          else if (enable)            state_next = HIGH;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Output and datapath decode: pop strobe, counters, position update, step pulse.
  always_comb begin
    pop            = 1'b0;
    dir_next       = dir_reg;
    remaining_next = remaining_reg;
    low_len_next   = low_len_reg;
    position_next  = position_reg;
    cnt_next       = cnt_reg + 25'd1;

    // Phase counter restarts on every transition and parks while idle or stalled.
    if (state_next != state_reg)
      cnt_next = '0;
    else if ((state_reg == IDLE) || ((state_reg == LOW) && low_done))
      cnt_next = cnt_reg;

    if ((state_reg == IDLE) && (level_reg != '0) && enable && !abort) begin
      pop = 1'b1;
      // Zero-step commands are consumed without touching dir or the move registers.
      if (head_steps != 16'd0) begin
        remaining_next = head_steps;
        low_len_next   = eff - PW25;
        dir_next       = head_dir;
      end
    end

    if ((state_reg == LOW) && low_done && !abort) begin
      if (state_next == HIGH)      remaining_next = remaining_reg - 16'd1;
      else if (state_next == IDLE) remaining_next = '0;
    end

    // Position counts on entry to HIGH; dir is already settled by then.
    if ((state_next == HIGH) && (state_reg != HIGH))
      position_next = dir_reg ? (position_reg + 32'd1) : (position_reg - 32'd1);

    if (abort) remaining_next = '0;

    step_next = (state_next == HIGH);
  end

  assign step     = step_reg;
  assign dir      = dir_reg;
  assign en       = enable;
  assign position = position_reg;
  assign busy     = (state_reg != IDLE) || (level_reg != '0);
  assign level    = level_reg;

endmodule

// File: tb/tb_stepdir_sequencer.sv
// tb_stepdir_sequencer: scoreboard bench. Accepted commands expand into expected
// pulses (position, dir, rise spacing) in a queue; a monitor pops one per rising edge.
`timescale 1ns/1ps
module tb_stepdir_sequencer;

  localparam int DEPTH     = 4;
  localparam int PULSE_W   = 2;
  localparam int DIR_SETUP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        abort = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic [23:0] cmd_period = '0;
  logic        cmd_dir = 1'b0;
  logic        step, dir, en, busy;
  logic [31:0] position;
  logic [2:0]  level;

  stepdir_sequencer #(.DEPTH(DEPTH), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps(cmd_steps),
    .cmd_period(cmd_period), .cmd_dir(cmd_dir), .step(step), .dir(dir), .en(en),
    .position(position), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pos;
    bit d;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_count = 0;
  int   last_rise = 0;
  int   rise_cyc = 0;
  bit   have_last = 0;
  bit   prev_step = 0;
  bit   check_gaps = 1;
  bit   chk_width = 1;
  int   model_pos = 0;
  bit   model_dir = 0;
  int   last_exp_pos = 0;
  bit   last_exp_dir = 0;
  exp_t mon_item;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: each step of a command is one pulse; position moves by one per
  // pulse, rises after the first are max(period, 2*PULSE_W) apart.
  function automatic void model_accept(input int s, input int p, input bit d);
    int eff;
    eff = (p > 2 * PULSE_W) ? p : 2 * PULSE_W;
    for (int i = 0; i < s; i++) begin
      exp_t it;
      model_pos = model_pos + (d ? 1 : -1);
      it.pos = model_pos;
      it.d   = d;
      it.gap = (i == 0) ? 0 : eff;
      exp_q.push_back(it);
    end
    if (s != 0) model_dir = d;
  endfunction

  // After an abort only pulses already seen count toward position.
  function automatic void model_flush();
    exp_q.delete();
    model_pos = last_exp_pos;
    model_dir = last_exp_dir;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    model_pos = 0;
    model_dir = 0;
    last_exp_pos = 0;
    last_exp_dir = 0;
    have_last = 0;
  endfunction

  task automatic push_cmd(input int s, input int p, input bit d, input int tries, output bit acc);
    acc = 0;
    cmd_steps  = 16'(s);
    cmd_period = 24'(p);
    cmd_dir    = d;
    cmd_valid  = 1'b1;
    for (int t = 0; t < tries && !acc; t++) begin
      #1;
      if (cmd_ready) begin
        acc = 1;
        model_accept(s, p, d);
      end
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  function automatic bit sel(input int which);
    case (which)
      0:       return step;
      1:       return dir;
      default: return busy;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input bit val, input int maxc);
    int n = 0;
    while (sel(which) != val && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    if (sel(which) != val) begin
      errors++;
      $display("FAIL %s: signal still %0d after %0d cycles, expected %0d", name, sel(which), maxc, val);
    end
  endtask

  task automatic wait_rises(input int target, input int maxc);
    int n = 0;
    while (rise_count < target && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    if (rise_count < target) begin
      errors++;
      $display("FAIL wait_rises: got %0d rises, expected %0d", rise_count, target);
    end
  endtask

  task automatic do_reset();
    chk_width = 0;
    rst = 1'b1;
    abort = 1'b0;
    cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    tick();
    chk_width = 1;
  endtask

  // Monitor: on every step rise pop one expected pulse and compare; check widths on fall.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (step && !prev_step) begin
        rise_count++;
        rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got step=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          mon_item = exp_q.pop_front();
          chk("pulse_position", int'($signed(position)), mon_item.pos);
          chk("pulse_dir", int'(dir), int'(mon_item.d));
          if (check_gaps && have_last && mon_item.gap != 0)
            chk("pulse_gap", cyc - last_rise, mon_item.gap);
          last_exp_pos = mon_item.pos;
          last_exp_dir = mon_item.d;
        end
        last_rise = cyc;
        have_last = 1;
      end else if (!step && prev_step && chk_width) begin
        chk("pulse_width", cyc - rise_cyc, PULSE_W);
      end
      prev_step = step;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base, c0, cdir, crise, cidle;
    bit  acc;
    int  s, p;
    bit  d;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_step", int'(step), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_position", int'($signed(position)), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    #1;
    chk("en_low", int'(en), 0);
    enable = 1'b1;
    #1;
    chk("en_high", int'(en), 1);
    tick();

    // {3,10,1}: dir change with setup, three pulses 10 apart
    base = rise_count;
    push_cmd(3, 10, 1, 5, acc);
    c0 = cyc;
    wait_for("dir_rise", 1, 1'b1, 10);
    cdir = cyc;
    chk("dir_after_pop", cdir - c0, 1);
    wait_for("first_rise", 0, 1'b1, 20);
    crise = cyc;
    chk("dir_setup_time", crise - cdir, DIR_SETUP);
    wait_for("busy_fall", 2, 1'b0, 200);
    cidle = cyc;
    chk("busy_fall_after_low", cidle - last_rise, 10);
    chk("pos_after_3", int'($signed(position)), 3);
    chk("pulses_3", rise_count - base, 3);
    chk("queue_drained_3", exp_q.size(), 0);

    // {2,1,0} from reset: no setup, eff period 4
    do_reset();
    base = rise_count;
    push_cmd(2, 1, 0, 5, acc);
    c0 = cyc;
    wait_for("rise_no_setup", 0, 1'b1, 20);
    chk("no_setup_latency", cyc - c0, 1);
    wait_for("busy_fall", 2, 1'b0, 100);
    chk("pos_neg2", int'($signed(position)), -2);
    chk("pulses_2", rise_count - base, 2);

    // Reset mid-pulse, with a push offered during reset
    do_reset();
    push_cmd(3, 10, 1, 5, acc);
    wait_for("rise_before_rst", 0, 1'b1, 20);
    chk_width = 0;
    rst = 1'b1;
    cmd_steps = 16'd5;
    cmd_period = 24'd10;
    cmd_dir = 1'b1;
    cmd_valid = 1'b1;
    tick();
    chk("rst_mid_step", int'(step), 0);
    chk("rst_mid_position", int'($signed(position)), 0);
    chk("rst_mid_dir", int'(dir), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_level", int'(level), 0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    model_clear();
    tick();
    chk_width = 1;

    // enable low: queue fills to DEPTH, no motion, then abort drains it
    enable = 1'b0;
    base = rise_count;
    for (int i = 0; i < 5; i++) begin
      push_cmd(2, 10, 1, 1, acc);
      chk("fill_accept", int'(acc), (i < DEPTH) ? 1 : 0);
    end
    chk("full_level", int'(level), DEPTH);
    chk("full_ready", int'(cmd_ready), 0);
    chk("full_busy", int'(busy), 1);
    repeat (20) tick();
    chk("no_steps_disabled", rise_count - base, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    model_flush();
    chk("abort_level", int'(level), 0);
    chk("abort_busy", int'(busy), 0);
    // A push offered together with abort must be dropped
    abort = 1'b1;
    cmd_valid = 1'b1;
    #1;
    chk("abort_ready", int'(cmd_ready), 0);
    tick();
    abort = 1'b0;
    cmd_valid = 1'b0;
    chk("abort_push_dropped", int'(level), 0);
    enable = 1'b1;

    // Abort during 2nd pulse with two commands queued
    do_reset();
    base = rise_count;
    push_cmd(10, 20, 1, 5, acc);
    push_cmd(3, 10, 1, 5, acc);
    push_cmd(2, 10, 0, 5, acc);
    wait_rises(base + 2, 200);
    chk_width = 0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    model_flush();
    chk("abort_step", int'(step), 0);
    chk("abort_level2", int'(level), 0);
    chk("abort_busy2", int'(busy), 0);
    chk("abort_position", int'($signed(position)), 2);
    chk("abort_dir_kept", int'(dir), 1);
    tick();
    chk_width = 1;
    repeat (30) tick();
    chk("abort_no_more", rise_count - base, 2);

    // Enable dropped during 3rd step of {6,8,1}
    do_reset();
    check_gaps = 0;
    base = rise_count;
    push_cmd(6, 8, 1, 5, acc);
    wait_rises(base + 3, 200);
    enable = 1'b0;
    repeat (50) tick();
    chk("stall_rises", rise_count - base, 3);
    chk("stall_step", int'(step), 0);
    chk("stall_busy", int'(busy), 1);
    chk("stall_position", int'($signed(position)), 3);
    enable = 1'b1;
    c0 = cyc;
    wait_for("resume_rise", 0, 1'b1, 10);
    chk("resume_latency", cyc - c0, 1);
    wait_for("busy_fall", 2, 1'b0, 200);
    chk("stall_total_pulses", rise_count - base, 6);
    chk("stall_position_end", int'($signed(position)), 6);
    check_gaps = 1;

    // Zero-step command discarded
    do_reset();
    base = rise_count;
    push_cmd(0, 10, 1, 5, acc);
    push_cmd(1, 10, 1, 5, acc);
    wait_for("busy_fall", 2, 1'b0, 100);
    chk("zero_pulses", rise_count - base, 1);
    chk("zero_position", int'($signed(position)), 1);
    chk("zero_dir", int'(dir), 1);

    // Randomized command stream against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(0, 4);
      p = $urandom_range(0, 14);
      d = 1'($urandom_range(0, 1));
      push_cmd(s, p, d, 300, acc);
      chk("rand_accept", int'(acc), 1);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_for("busy_fall", 2, 1'b0, 5000);
    chk("rand_position", int'($signed(position)), model_pos);
    chk("rand_dir", int'(dir), int'(model_dir));
    chk("rand_queue_drained", exp_q.size(), 0);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepdir_sequencer.md
STEPDIR_SEQUENCER -- requirements
Module: stepdir_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth (power of 2, 2..16).
REQ-002 SHALL have parameter PULSE_W, default 2, step high time in clk cycles (>=1).
REQ-003 SHALL have parameter DIR_SETUP, default 4, dir-to-first-step setup time in clk cycles (>=1).
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  motion permit.
- abort  in  1  flush queue and stop.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_steps  in  16  step count.
- cmd_period  in  24  clk cycles per step.
- cmd_dir  in  1  1 = positive.
- step  out  1  step pulse, registered.
- dir  out  1  direction, registered.
- en  out  1  driver enable.
- position  out  32  signed step count.
- busy  out  1  motion active or queued.
- level  out  log2(DEPTH)+1  FIFO occupancy.

Function
REQ-005 SHALL store {steps, period, dir} in a DEPTH-entry FIFO; cmd_ready = (level < DEPTH) && !abort; push on clk when cmd_valid && cmd_ready.
REQ-006 SHALL use states IDLE, SETUP, HIGH, LOW.
REQ-007 In IDLE with level != 0 and enable = 1: pop the head that cycle; steps = 0 -> entry discarded, stay IDLE; cmd dir != dir -> dir updates next cycle and enter SETUP; otherwise enter HIGH.
REQ-008 SETUP: hold DIR_SETUP cycles, then enter HIGH; step = 0 throughout.
REQ-009 HIGH: step = 1 for exactly PULSE_W cycles; on entry position += 1 (dir = 1) or -= 1 (dir = 0); then enter LOW.
REQ-010 LOW: step = 0 for eff - PULSE_W cycles, eff = max(period, 2*PULSE_W); compared at 25 bits, no truncation.
REQ-011 End of LOW: decrement remaining; remaining > 0 -> HIGH (rising edges exactly eff cycles apart); remaining = 0 -> IDLE.
REQ-012 IDLE SHALL last >=1 cycle between commands; with the same dir, the next command's first rising edge comes 2 cycles after the previous LOW ends.
REQ-013 enable = 0: no pop in IDLE; HIGH and LOW complete normally; at end of LOW with remaining > 0, hold LOW (step = 0) until enable = 1, then enter HIGH next cycle; remaining count preserved.
REQ-014 en SHALL equal enable, combinationally.
REQ-015 abort = 1: next cycle state = IDLE, step = 0, FIFO emptied, remaining cleared; position and dir retained; a same-cycle push SHALL be dropped.
REQ-016 Simultaneous push and pop in one cycle SHALL leave level unchanged.
REQ-017 position SHALL wrap two's-complement at +/-2^31 with no saturation.
REQ-018 busy = (state != IDLE) || (level != 0).
REQ-019 dir SHALL change only on a pop in IDLE, never during a move.

Reset
REQ-020 rst = 1 SHALL force: state IDLE, FIFO empty, level 0, step 0, dir 0, position 0, remaining 0, busy 0. rst has priority over abort and push.
REQ-021 rst mid-pulse SHALL drive step to 0 on the next cycle.

Verification (DEPTH=4, PULSE_W=2, DIR_SETUP=4)
REQ-022 Push {3, 10, 1} after reset -> dir = 1 one cycle after pop, first step rise 4 cycles later; 3 pulses, each 2 high, rising edges 10 apart; position = 3; busy falls after the last LOW.
REQ-023 Push {2, 1, 0} -> eff period 4: 2 high, 2 low; position = -2; no SETUP if dir already 0.
REQ-024 Hold enable = 0, push 5 commands -> first 4 accepted, level = 4, cmd_ready = 0 on the 5th; no steps.
REQ-025 abort during 2nd pulse of {10, 20, 1} with 2 more queued -> step = 0 next cycle; level = 0; position = 2; busy = 0.
REQ-026 Drop enable during 3rd step of {6, 8, 1}; hold 50 cycles; raise -> no rise while low; exactly 6 pulses total; position = 6.
REQ-027 Push {0, 10, 1} then {1, 10, 1} -> first discarded, no pulse; exactly one pulse; position = 1.
